lsu_dcache_responder: RTL and testbench
=======================================

# lsu_dcache_responder

Memory-side responder for the LSU issue-queue ↔ DCache handshake. It accepts one load/store request at a time, which arrives already byte-lane-shifted with `strb`/`rmask` precomputed. It checks alignment, performs a single word access on a req/gnt/rvalid data-memory port, then returns a response. The response carries lane-extracted, sign/zero-extended load data, or an address-alignment exception. It sits between the LSU issue queue and the backing data RAM/bus, and stands in for the DCache when that is absent.

## Interface
- `WID_W`, 6: width of the destination ROB id carried through.
- `ALE_ECODE`, 6'h09: exception code reported for misaligned accesses.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: synchronous pipeline flush; abandons the current request.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted when high together with valid.
- `req_vaddr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, already shifted to byte lane.
- `req_strb_i` in 4: store byte enables. Non-zero means store.
- `req_rmask_i` in 4: load byte mask. Informational; echoed.
- `req_msize_i` in 2: 0 byte, 1 half, 2 word.
- `req_msigned_i` in 1: sign-extend load.
- `req_wid_i` in WID_W: destination id.
- `mem_req_o` out 1, `mem_gnt_i` in 1: memory command handshake.
- `mem_we_o` out 1: write command.
- `mem_addr_o` out 32: word address, `{vaddr[31:2],2'b00}`.
- `mem_be_o` out 4: byte enables (strb for store, rmask for load).
- `mem_wdata_o` out 32: store data.
- `mem_rvalid_i` in 1, `mem_rdata_i` in 32: completion beat. Also issued for stores; rdata ignored for stores.
- `resp_valid_o` out 1, `resp_ready_i` in 1: response handshake.
- `resp_rdata_o` out 32: extracted load data; 0 for stores and exceptions.
- `resp_strb_o` out 4, `resp_wid_o` out WID_W: echoed from the request.
- `resp_exc_o` out 1, `resp_ecode_o` out 6, `resp_badv_o` out 32: exception info. `badv` = vaddr when exc, else 0.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP, DRAIN.
- Request latch:
  - `req_ready_o` = (state==IDLE) | (state==RESP & resp_ready_i) (combinational).
  - On fire, latch all request fields.
- Alignment check at accept time:
  - Misaligned if msize==1 & vaddr[0], or msize==2 & vaddr[1:0]≠0. msize==3 is treated as word.
  - Misaligned → RESP with exc=1, ecode=ALE_ECODE, badv=vaddr, rdata=0. No memory access.
  - Aligned → MEM_REQ.
- MEM_REQ: `mem_req_o`=1 with stable addr/we/be/wdata until `mem_gnt_i`. Then go to MEM_WAIT.
- MEM_WAIT: on `mem_rvalid_i`, capture the result and go to RESP.
- Load extraction, with sh = vaddr[1:0]·8:
  - byte = (rdata>>sh)[7:0];
  - half = (rdata>>sh)[15:0];
  - word = rdata.
  - Sign-extend the MSB when msigned, else zero-extend.
- RESP: `resp_valid_o`=1, outputs held stable until `resp_ready_i`.
  - On fire with a new request fire in the same cycle, go directly to that request's next state (MEM_REQ or RESP).
  - On fire without a new request, go to IDLE.
- Flush:
  - IDLE, MEM_REQ or RESP → IDLE. Response dropped, `mem_req_o` deasserted next cycle.
  - Flush in MEM_WAIT, or in MEM_REQ in the same cycle as `mem_gnt_i` → DRAIN.
  - DRAIN holds `req_ready_o`=0, absorbs exactly one `mem_rvalid_i`, then goes to IDLE with no response.
  - A request presented in the flush cycle is not accepted (`req_ready_o` masked by flush).
- At most one memory transaction is outstanding; rvalid never arrives in the same cycle as gnt.

## Timing
- Reset values:
  - state IDLE;
  - `req_ready_o`=1;
  - `mem_req_o`=0 and all `mem_*` outputs 0;
  - `resp_valid_o`=0 and all `resp_*` outputs 0.
- Reset asserted mid-transaction returns to IDLE immediately. A late `mem_rvalid_i` after reset is ignored in IDLE.
- Request fire in cycle N:
  - `mem_req_o` high in N+1.
  - gnt in G ≥ N+1.
  - rvalid in R > G.
  - `resp_valid_o` high in R+1.
- Minimum load/store latency: fire N → response N+3, with gnt in N+1 and rvalid in N+2.
- Misaligned request: response in N+1, no `mem_req_o` pulse.
- Back-to-back: response fire and new request fire in cycle M → `mem_req_o` in M+1; no bubble.
- All outputs are registered except `req_ready_o`.

## Test plan
- Load byte signed:
  - stimulus: vaddr=0x1003, msize=0, msigned=1; memory returns 0x80FF_FF12;
  - required: mem_addr=0x1000, be=4'b1000, resp_rdata=0xFFFF_FF80, exc=0, response at N+3 with zero-wait memory.
- Store half:
  - stimulus: vaddr=0x2002, wdata=0xBEEF_0000, strb=4'b1100;
  - required: mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF_0000, resp_rdata=0, resp_strb=4'b1100.
- Misaligned word:
  - stimulus: vaddr=0x3001, msize=2;
  - required: no mem_req, response at N+1 with exc=1, ecode=6'h09, badv=0x3001.
- Backpressure and back-to-back:
  - stimulus: resp_ready_i low for 3 cycles;
  - required: response fields held stable; req_ready_o=0; on ready, the next queued load is accepted in the same cycle and mem_req_o is seen next cycle.
- Flush in MEM_WAIT:
  - stimulus: flush after gnt, rvalid 2 cycles later;
  - required: no resp_valid_o, req_ready_o=0 until the cycle after rvalid, then IDLE.
- Async reset mid-MEM_REQ:
  - stimulus: assert rst while mem_req_o=1;
  - required: mem_req_o=0 and resp_valid_o=0 immediately; req_ready_o=1 after release.

Source files
------------

// File: rtl/lsu_dcache_responder.sv
// Memory-side responder for the LSU/DCache handshake: one request at a time,
// alignment check, single-word req/gnt/rvalid access, extracted load response.
module lsu_dcache_responder #(
  parameter int         WID_W     = 6,
  parameter logic [5:0] ALE_ECODE = 6'h09
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [31:0]      req_vaddr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [3:0]       req_strb_i,
  input  logic [3:0]       req_rmask_i,
  input  logic [1:0]       req_msize_i,
  input  logic             req_msigned_i,
  input  logic [WID_W-1:0] req_wid_i,
  output logic             mem_req_o,
  input  logic             mem_gnt_i,
  output logic             mem_we_o,
  output logic [31:0]      mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [31:0]      mem_wdata_o,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_rdata_o,
  output logic [3:0]       resp_strb_o,
  output logic [WID_W-1:0] resp_wid_o,
  output logic             resp_exc_o,
  output logic [5:0]       resp_ecode_o,
  output logic [31:0]      resp_badv_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_REQ  = 3'd1,
    MEM_WAIT = 3'd2,
    RESP     = 3'd3,
    DRAIN    = 3'd4
  } state_t;

  function automatic logic [31:0] extract_load(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [1:0] msize, input logic msigned);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (msize)
      2'd0:    extract_load = {{24{msigned & sh[7]}}, sh[7:0]};
      2'd1:    extract_load = {{16{msigned & sh[15]}}, sh[15:0]};
      default: extract_load = rdata;
    endcase
  endfunction

  state_t             state_r, state_s;
  logic               ready_s, req_fire_s, misaligned_s;
  logic [1:0]         off_r, msize_r;
  logic               msigned_r, store_r;
  logic [3:0]         strb_r;
  logic [WID_W-1:0]   wid_r;

  logic               mem_req_r, mem_we_r;
  logic [31:0]        mem_addr_r, mem_wdata_r;
  logic [3:0]         mem_be_r;
  logic               resp_valid_r, resp_exc_r;
  logic [31:0]        resp_rdata_r, resp_badv_r;
  logic [3:0]         resp_strb_r;
  logic [WID_W-1:0]   resp_wid_r;
  logic [5:0]         resp_ecode_r;

  // A flush masks acceptance so nothing new enters while the pipe is being cleared.
  assign ready_s      = ~flush & ((state_r == IDLE) | ((state_r == RESP) & resp_ready_i));
  assign req_fire_s   = req_valid_i & ready_s;
  assign misaligned_s = ((req_msize_i == 2'd1) & req_vaddr_i[0]) |
                        (req_msize_i[1] & (req_vaddr_i[1:0] != 2'b00));
  assign req_ready_o  = ready_s;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_fire_s) state_s = misaligned_s ? RESP : MEM_REQ;
        else            state_s = IDLE;
      end
      MEM_REQ: begin
        if (flush)          state_s = mem_gnt_i ? DRAIN : IDLE;
        else if (mem_gnt_i) state_s = MEM_WAIT;
        else                state_s = MEM_REQ;
      end
      MEM_WAIT: begin
        // A completion arriving together with the flush is the one DRAIN would absorb.
        if (flush)             state_s = mem_rvalid_i ? IDLE : DRAIN;
        else if (mem_rvalid_i) state_s = RESP;
        else                   state_s = MEM_WAIT;
      end
      RESP: begin
        if (flush)             state_s = IDLE;
        else if (req_fire_s)   state_s = misaligned_s ? RESP : MEM_REQ;
        else if (resp_ready_i) state_s = IDLE;
        else                   state_s = RESP;
      end
      DRAIN: begin
        if (mem_rvalid_i) state_s = IDLE;
        else              state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and latched request attributes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      off_r     <= 2'b00;
      msize_r   <= 2'b00;
      msigned_r <= 1'b0;
      store_r   <= 1'b0;
      strb_r    <= 4'h0;
      wid_r     <= {WID_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (req_fire_s) begin
        off_r     <= req_vaddr_i[1:0];
        msize_r   <= req_msize_i;
        msigned_r <= req_msigned_i;
        store_r   <= |req_strb_i;
        strb_r    <= req_strb_i;
        wid_r     <= req_wid_i;
      end
    end
  end

  // Registered memory command and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_r    <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= 32'h0;
      mem_be_r     <= 4'h0;
      mem_wdata_r  <= 32'h0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0;
      resp_strb_r  <= 4'h0;
      resp_wid_r   <= {WID_W{1'b0}};
      resp_exc_r   <= 1'b0;
      resp_ecode_r <= 6'h00;
      resp_badv_r  <= 32'h0;
    end else begin
      mem_req_r    <= (state_s == MEM_REQ);
      resp_valid_r <= (state_s == RESP);
      if (req_fire_s & ~misaligned_s) begin
        mem_we_r    <= |req_strb_i;
        mem_addr_r  <= {req_vaddr_i[31:2], 2'b00};
        mem_be_r    <= (|req_strb_i) ? req_strb_i : req_rmask_i;
        mem_wdata_r <= req_wdata_i;
      end
      if (req_fire_s & misaligned_s) begin
        resp_rdata_r <= 32'h0;
        resp_strb_r  <= req_strb_i;
        resp_wid_r   <= req_wid_i;
        resp_exc_r   <= 1'b1;
        resp_ecode_r <= ALE_ECODE;
        resp_badv_r  <= req_vaddr_i;
      end else if ((state_r == MEM_WAIT) & mem_rvalid_i & ~flush) begin
        resp_rdata_r <= store_r ? 32'h0 : extract_load(mem_rdata_i, off_r, msize_r, msigned_r);
        resp_strb_r  <= strb_r;
        resp_wid_r   <= wid_r;
        resp_exc_r   <= 1'b0;
        resp_ecode_r <= 6'h00;
        resp_badv_r  <= 32'h0;
      end
    end
  end

  assign mem_req_o    = mem_req_r;
  assign mem_we_o     = mem_we_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_be_o     = mem_be_r;
  assign mem_wdata_o  = mem_wdata_r;
  assign resp_valid_o = resp_valid_r;
  assign resp_rdata_o = resp_rdata_r;
  assign resp_strb_o  = resp_strb_r;
  assign resp_wid_o   = resp_wid_r;
  assign resp_exc_o   = resp_exc_r;
  assign resp_ecode_o = resp_ecode_r;
  assign resp_badv_o  = resp_badv_r;

endmodule

// File: tb/tb_lsu_dcache_responder.sv
// Scoreboard bench for lsu_dcache_responder: directed requests push expected
// memory commands and responses; monitors pop and compare on each handshake.
module tb_lsu_dcache_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic [3:0]  strb;
    logic [5:0]  wid;
    logic        exc;
    logic [5:0]  ecode;
    logic [31:0] badv;
  } resp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_vaddr_i, req_wdata_i;
  logic [3:0]  req_strb_i, req_rmask_i;
  logic [1:0]  req_msize_i;
  logic        req_msigned_i;
  logic [5:0]  req_wid_i;
  logic        mem_req_o, mem_gnt_i, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_rdata_o, resp_badv_o;
  logic [3:0]  resp_strb_o;
  logic [5:0]  resp_wid_o;
  logic        resp_exc_o;
  logic [5:0]  resp_ecode_o;

  int checks = 0;
  int failures = 0;
  resp_t exp_resp_q[$];
  cmd_t  exp_cmd_q[$];

  lsu_dcache_responder #(.WID_W(6), .ALE_ECODE(6'h09)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vaddr_i(req_vaddr_i), .req_wdata_i(req_wdata_i),
    .req_strb_i(req_strb_i), .req_rmask_i(req_rmask_i),
    .req_msize_i(req_msize_i), .req_msigned_i(req_msigned_i), .req_wid_i(req_wid_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_strb_o(resp_strb_o), .resp_wid_o(resp_wid_o),
    .resp_exc_o(resp_exc_o), .resp_ecode_o(resp_ecode_o), .resp_badv_o(resp_badv_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] va, input logic [31:0] wd, input logic [3:0] st,
                       input logic [3:0] rm, input logic [1:0] ms, input logic sg,
                       input logic [5:0] w);
    req_valid_i   = 1'b1;
    req_vaddr_i   = va;
    req_wdata_i   = wd;
    req_strb_i    = st;
    req_rmask_i   = rm;
    req_msize_i   = ms;
    req_msigned_i = sg;
    req_wid_i     = w;
  endtask

  // Present the request for one cycle, expecting it to be accepted.
  task automatic fire_one(input string name);
    @(negedge clk);
    chk({name, "_accept"}, req_ready_o, 1);
    step();
    req_valid_i = 1'b0;
  endtask

  // Called in the cycle after acceptance: grant after gw stall cycles, complete rw cycles later.
  task automatic serve_mem(input string name, input int gw, input int rw, input logic [31:0] rd);
    @(negedge clk);
    chk({name, "_mem_req_up"}, mem_req_o, 1);
    for (int i = 0; i < gw; i++) begin
      step();
      @(negedge clk);
      chk({name, "_mem_req_hold"}, mem_req_o, 1);
    end
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    for (int i = 0; i < rw; i++) begin
      @(negedge clk);
      chk({name, "_no_early_resp"}, resp_valid_o, 0);
      step();
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (!rst && resp_valid_o && resp_ready_i) begin
      if (exp_resp_q.size() == 0) begin
        chk("resp_unexpected", {26'h0, resp_wid_o}, 32'hFFFF_FFFF);
      end else begin
        resp_t e;
        e = exp_resp_q.pop_front();
        chk("resp_rdata", resp_rdata_o, e.rdata);
        chk("resp_strb", {28'h0, resp_strb_o}, {28'h0, e.strb});
        chk("resp_wid", {26'h0, resp_wid_o}, {26'h0, e.wid});
        chk("resp_exc", {31'h0, resp_exc_o}, {31'h0, e.exc});
        chk("resp_ecode", {26'h0, resp_ecode_o}, {26'h0, e.ecode});
        chk("resp_badv", resp_badv_o, e.badv);
      end
    end
  end

  // Memory command monitor.
  always @(negedge clk) begin
    if (!rst && mem_req_o && mem_gnt_i) begin
      if (exp_cmd_q.size() == 0) begin
        chk("cmd_unexpected", mem_addr_o, 32'hFFFF_FFFF);
      end else begin
        cmd_t c;
        c = exp_cmd_q.pop_front();
        chk("mem_addr", mem_addr_o, c.addr);
        chk("mem_we", {31'h0, mem_we_o}, {31'h0, c.we});
        chk("mem_be", {28'h0, mem_be_o}, {28'h0, c.be});
        chk("mem_wdata", mem_wdata_o, c.wdata);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    req_valid_i = 1'b0; req_vaddr_i = 32'h0; req_wdata_i = 32'h0; req_strb_i = 4'h0;
    req_rmask_i = 4'h0; req_msize_i = 2'd0; req_msigned_i = 1'b0; req_wid_i = 6'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0; resp_ready_i = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_mem_bus", {mem_we_o, mem_be_o, mem_addr_o | mem_wdata_o}, 37'h0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_resp_bus", resp_rdata_o | resp_badv_o, 0);
    chk("rst_resp_misc", {resp_exc_o, resp_ecode_o, resp_strb_o, resp_wid_o}, 0);
    step();
    rst = 1'b0;
    step();

    // Load byte signed, zero-wait memory
    issue(32'h0000_1003, 32'h0, 4'b0000, 4'b1000, 2'd0, 1'b1, 6'd5);
    exp_cmd_q.push_back('{addr: 32'h0000_1000, we: 1'b0, be: 4'b1000, wdata: 32'h0});
    exp_resp_q.push_back('{rdata: 32'hFFFF_FF80, strb: 4'b0000, wid: 6'd5, exc: 1'b0, ecode: 6'h00, badv: 32'h0});
    fire_one("lb");
    serve_mem("lb", 0, 0, 32'h80FF_FF12);
    @(negedge clk);
    chk("lb_resp_n3", resp_valid_o, 1);
    step();

    // Store half with grant stalls; returned rdata must be ignored
    issue(32'h0000_2002, 32'hBEEF_0000, 4'b1100, 4'b0000, 2'd1, 1'b0, 6'd6);
    exp_cmd_q.push_back('{addr: 32'h0000_2000, we: 1'b1, be: 4'b1100, wdata: 32'hBEEF_0000});
    exp_resp_q.push_back('{rdata: 32'h0, strb: 4'b1100, wid: 6'd6, exc: 1'b0, ecode: 6'h00, badv: 32'h0});
    fire_one("sh");
    serve_mem("sh", 2, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("sh_resp", resp_valid_o, 1);
    step();

    // Misaligned word: exception at N+1, no memory access
    issue(32'h0000_3001, 32'h0, 4'b0000, 4'b1111, 2'd2, 1'b0, 6'd7);
    exp_resp_q.push_back('{rdata: 32'h0, strb: 4'b0000, wid: 6'd7, exc: 1'b1, ecode: 6'h09, badv: 32'h0000_3001});
    fire_one("mis");
    @(negedge clk);
    chk("mis_resp_n1", resp_valid_o, 1);
    chk("mis_no_mem_req", mem_req_o, 0);
    step();

    // Backpressure then back-to-back accept
    resp_ready_i = 1'b0;
    issue(32'h0000_4000, 32'h0, 4'b0000, 4'b1111, 2'd2, 1'b0, 6'd8);
    exp_cmd_q.push_back('{addr: 32'h0000_4000, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    exp_resp_q.push_back('{rdata: 32'h1234_5678, strb: 4'b0000, wid: 6'd8, exc: 1'b0, ecode: 6'h00, badv: 32'h0});
    fire_one("bp");
    serve_mem("bp", 0, 0, 32'h1234_5678);
    issue(32'h0000_4006, 32'h0, 4'b0000, 4'b1100, 2'd1, 1'b1, 6'd9);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid_o, 1);
      chk("bp_hold_rdata", resp_rdata_o, 32'h1234_5678);
      chk("bp_hold_wid", {26'h0, resp_wid_o}, 32'd8);
      chk("bp_ready_low", req_ready_o, 0);
      step();
    end
    resp_ready_i = 1'b1;
    exp_cmd_q.push_back('{addr: 32'h0000_4004, we: 1'b0, be: 4'b1100, wdata: 32'h0});
    exp_resp_q.push_back('{rdata: 32'hFFFF_8001, strb: 4'b0000, wid: 6'd9, exc: 1'b0, ecode: 6'h00, badv: 32'h0});
    fire_one("b2b");
    serve_mem("b2b", 0, 1, 32'h8001_0000);
    @(negedge clk);
    chk("b2b_resp", resp_valid_o, 1);
    step();

    // Flush in MEM_WAIT: drain one completion, no response
    issue(32'h0000_5000, 32'h0, 4'b0000, 4'b1111, 2'd2, 1'b0, 6'd10);
    exp_cmd_q.push_back('{addr: 32'h0000_5000, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    fire_one("fl");
    @(negedge clk);
    chk("fl_mem_req", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    flush = 1'b1;
    issue(32'h0000_5100, 32'h0, 4'b0000, 4'b1111, 2'd2, 1'b0, 6'd13);
    @(negedge clk);
    chk("fl_ready_masked", req_ready_o, 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_drain_ready", req_ready_o, 0);
    chk("fl_drain_no_resp", resp_valid_o, 0);
    step();
    req_valid_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h1111_1111;
    @(negedge clk);
    chk("fl_rvalid_ready", req_ready_o, 0);
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0;
    @(negedge clk);
    chk("fl_idle_ready", req_ready_o, 1);
    chk("fl_idle_no_resp", resp_valid_o, 0);
    step();

    // Flush in IDLE masks a presented request
    flush = 1'b1;
    issue(32'h0000_5200, 32'h0, 4'b0000, 4'b1111, 2'd2, 1'b0, 6'd14);
    @(negedge clk);
    chk("fl_idle_masked", req_ready_o, 0);
    step();
    flush = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("fl_idle_no_mem", mem_req_o, 0);
    step();

    // Async reset while mem_req_o is high
    issue(32'h0000_6000, 32'h0, 4'b0000, 4'b1111, 2'd2, 1'b0, 6'd11);
    fire_one("ar");
    @(negedge clk);
    chk("ar_mem_req", mem_req_o, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_mem_req_drop", mem_req_o, 0);
    chk("ar_resp_drop", resp_valid_o, 0);
    step();
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'h2222_2222;
    @(negedge clk);
    chk("ar_ready_after", req_ready_o, 1);
    step();
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 32'h0;
    @(negedge clk);
    chk("ar_late_rvalid", resp_valid_o, 0);
    step();

    // Recovery: load half unsigned
    issue(32'h0000_7002, 32'h0, 4'b0000, 4'b1100, 2'd1, 1'b0, 6'd12);
    exp_cmd_q.push_back('{addr: 32'h0000_7000, we: 1'b0, be: 4'b1100, wdata: 32'h0});
    exp_resp_q.push_back('{rdata: 32'h0000_9ABC, strb: 4'b0000, wid: 6'd12, exc: 1'b0, ecode: 6'h00, badv: 32'h0});
    fire_one("lhu");
    serve_mem("lhu", 1, 2, 32'h9ABC_0000);
    @(negedge clk);
    chk("lhu_resp", resp_valid_o, 1);
    step();
    step();

    chk("resp_q_empty", exp_resp_q.size(), 0);
    chk("cmd_q_empty", exp_cmd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
